// File: rtl/punc_control_pkg.sv
// Shared encodings for the PUnC control FSM and the datapath select muxes.
package punc_control_pkg;

  localparam int unsigned STATE_W = 3;
  localparam int unsigned OP_W    = 4;
  localparam int unsigned SEL_W   = 2;

  typedef enum logic [STATE_W-1:0] {
    S_INIT   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_EXEC2  = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  localparam logic [OP_W-1:0] OP_BR   = 4'b0000;
  localparam logic [OP_W-1:0] OP_ADD  = 4'b0001;
  localparam logic [OP_W-1:0] OP_LD   = 4'b0010;
  localparam logic [OP_W-1:0] OP_ST   = 4'b0011;
  localparam logic [OP_W-1:0] OP_JSR  = 4'b0100;
  localparam logic [OP_W-1:0] OP_AND  = 4'b0101;
  localparam logic [OP_W-1:0] OP_LDR  = 4'b0110;
  localparam logic [OP_W-1:0] OP_STR  = 4'b0111;
  localparam logic [OP_W-1:0] OP_NOT  = 4'b1001;
  localparam logic [OP_W-1:0] OP_LDI  = 4'b1010;
  localparam logic [OP_W-1:0] OP_STI  = 4'b1011;
  localparam logic [OP_W-1:0] OP_JMP  = 4'b1100;
  localparam logic [OP_W-1:0] OP_LEA  = 4'b1110;
  localparam logic [OP_W-1:0] OP_HALT = 4'b1111;

  localparam logic [SEL_W-1:0] PC_SEL_OFF9  = 2'd0;
  localparam logic [SEL_W-1:0] PC_SEL_OFF11 = 2'd1;
  localparam logic [SEL_W-1:0] PC_SEL_BASE  = 2'd2;

  localparam logic [SEL_W-1:0] MEM_R_PC      = 2'd0;
  localparam logic [SEL_W-1:0] MEM_R_OFF9    = 2'd1;
  localparam logic [SEL_W-1:0] MEM_R_R0      = 2'd2;
  localparam logic [SEL_W-1:0] MEM_R_BASE6   = 2'd3;

  localparam logic [SEL_W-1:0] MEM_W_OFF9    = 2'd0;
  localparam logic [SEL_W-1:0] MEM_W_PREV    = 2'd1;
  localparam logic [SEL_W-1:0] MEM_W_BASE6   = 2'd2;

  localparam logic [SEL_W-1:0] RF_W_DATA_ALU  = 2'd0;
  localparam logic [SEL_W-1:0] RF_W_DATA_OFF9 = 2'd1;
  localparam logic [SEL_W-1:0] RF_W_DATA_MEM  = 2'd2;
  localparam logic [SEL_W-1:0] RF_W_DATA_PC   = 2'd3;

  localparam logic RF_W_ADDR_R7 = 1'b0;
  localparam logic RF_W_ADDR_DR = 1'b1;

  localparam logic RF_R0_ADDR_DR  = 1'b0;
  localparam logic RF_R0_ADDR_SR2 = 1'b1;

  localparam logic [SEL_W-1:0] ALU_PASS = 2'd0;
  localparam logic [SEL_W-1:0] ALU_ADD  = 2'd1;
  localparam logic [SEL_W-1:0] ALU_AND  = 2'd2;
  localparam logic [SEL_W-1:0] ALU_NOT  = 2'd3;

endpackage

// File: rtl/punc_control.sv
// PUnC LC-3 control FSM: sequences fetch/decode/execute and drives all
// datapath control strobes combinationally from state and ir.
module punc_control
  import punc_control_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] ir,
  input  logic        nzp_true,
  output logic        pc_ld,
  output logic        pc_clr,
  output logic        pc_inc,
  output logic [1:0]  pc_sel,
  output logic        ir_ld,
  output logic        ir_clr,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [1:0]  mem_r_addr_sel,
  output logic [1:0]  mem_w_addr_sel,
  output logic [1:0]  rf_w_data_sel,
  output logic        rf_w_addr_sel,
  output logic        rf_w_wr,
  output logic        rf_r0_addr_sel,
  output logic        rf_r0_rd,
  output logic        rf_r1_rd,
  output logic        prev_ld,
  output logic        nzp_ld,
  output logic        nzp_clr,
  output logic [1:0]  alu_sel,
  output logic        alu_first_val_sel,
  output logic        halted
);

  state_t          state, state_next;
  logic [OP_W-1:0] opcode;

  assign opcode = ir[15:12];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_INIT;
    else     state <= state_next;
  end

  always_comb begin
    state_next        = state;
    pc_ld             = 1'b0;
    pc_clr            = 1'b0;
    pc_inc            = 1'b0;
    pc_sel            = PC_SEL_OFF9;
    ir_ld             = 1'b0;
    ir_clr            = 1'b0;
    mem_rd            = 1'b0;
    mem_wr            = 1'b0;
    mem_r_addr_sel    = MEM_R_PC;
    mem_w_addr_sel    = MEM_W_OFF9;
    rf_w_data_sel     = RF_W_DATA_ALU;
    rf_w_addr_sel     = RF_W_ADDR_R7;
    rf_w_wr           = 1'b0;
    rf_r0_addr_sel    = RF_R0_ADDR_DR;
    rf_r0_rd          = 1'b0;
    rf_r1_rd          = 1'b0;
    prev_ld           = 1'b0;
    nzp_ld            = 1'b0;
    nzp_clr           = 1'b0;
    alu_sel           = ALU_PASS;
    alu_first_val_sel = 1'b0;
    halted            = 1'b0;

    case (state)
      S_INIT: begin
        pc_clr     = 1'b1;
        ir_clr     = 1'b1;
        nzp_clr    = 1'b1;
        state_next = S_FETCH;
      end

      S_FETCH: begin
        mem_rd         = 1'b1;
        mem_r_addr_sel = MEM_R_PC;
        ir_ld          = 1'b1;
        pc_inc         = 1'b1;
        state_next     = S_DECODE;
      end

      S_DECODE: begin
        state_next = (opcode == OP_HALT) ? S_HALT : S_EXEC;
      end

      S_EXEC: begin
        state_next = S_FETCH;
        case (opcode)
          OP_ADD, OP_AND, OP_NOT: begin
            rf_r0_rd      = 1'b1;
            rf_r1_rd      = 1'b1;
            rf_w_data_sel = RF_W_DATA_ALU;
            rf_w_addr_sel = RF_W_ADDR_DR;
            rf_w_wr       = 1'b1;
            nzp_ld        = 1'b1;
            if (opcode == OP_NOT) begin
              alu_sel = ALU_NOT;
            end else begin
              alu_sel           = (opcode == OP_ADD) ? ALU_ADD : ALU_AND;
              alu_first_val_sel = ir[5];
              rf_r0_addr_sel    = RF_R0_ADDR_SR2;
            end
          end
          OP_BR: begin
            pc_ld  = nzp_true;
            pc_sel = PC_SEL_OFF9;
          end
          OP_JMP: begin
            rf_r1_rd = 1'b1;
            pc_ld    = 1'b1;
            pc_sel   = PC_SEL_BASE;
          end
          // Old R7 is read and the new PC latched on the same edge R7 is written.
          OP_JSR: begin
            rf_r1_rd      = ~ir[11];
            rf_w_wr       = 1'b1;
            rf_w_addr_sel = RF_W_ADDR_R7;
            rf_w_data_sel = RF_W_DATA_PC;
            pc_ld         = 1'b1;
            pc_sel        = ir[11] ? PC_SEL_OFF11 : PC_SEL_BASE;
          end
          OP_LD, OP_LDR: begin
            rf_r1_rd       = (opcode == OP_LDR);
            mem_rd         = 1'b1;
            mem_r_addr_sel = (opcode == OP_LD) ? MEM_R_OFF9 : MEM_R_BASE6;
            rf_w_data_sel  = RF_W_DATA_MEM;
            rf_w_addr_sel  = RF_W_ADDR_DR;
            rf_w_wr        = 1'b1;
            nzp_ld         = 1'b1;
          end
          OP_LEA: begin
            rf_w_data_sel = RF_W_DATA_OFF9;
            rf_w_addr_sel = RF_W_ADDR_DR;
            rf_w_wr       = 1'b1;
            nzp_ld        = 1'b1;
          end
          OP_ST, OP_STR: begin
            rf_r1_rd       = (opcode == OP_STR);
            mem_wr         = 1'b1;
            mem_w_addr_sel = (opcode == OP_ST) ? MEM_W_OFF9 : MEM_W_BASE6;
            rf_r0_addr_sel = RF_R0_ADDR_DR;
            rf_r0_rd       = 1'b1;
          end
          // DR holds the pointer after this cycle; EXEC2 dereferences it.
          OP_LDI: begin
            mem_rd         = 1'b1;
            mem_r_addr_sel = MEM_R_OFF9;
            rf_w_data_sel  = RF_W_DATA_MEM;
            rf_w_addr_sel  = RF_W_ADDR_DR;
            rf_w_wr        = 1'b1;
            state_next     = S_EXEC2;
          end
          OP_STI: begin
            mem_rd         = 1'b1;
            mem_r_addr_sel = MEM_R_OFF9;
            prev_ld        = 1'b1;
            state_next     = S_EXEC2;
          end
          default: ;
        endcase
      end

      S_EXEC2: begin
        state_next = S_FETCH;
        if (opcode == OP_LDI) begin
          mem_rd         = 1'b1;
          mem_r_addr_sel = MEM_R_R0;
          rf_r0_addr_sel = RF_R0_ADDR_DR;
          rf_r0_rd       = 1'b1;
          rf_w_data_sel  = RF_W_DATA_MEM;
          rf_w_addr_sel  = RF_W_ADDR_DR;
          rf_w_wr        = 1'b1;
          nzp_ld         = 1'b1;
        end else if (opcode == OP_STI) begin
          mem_wr         = 1'b1;
          mem_w_addr_sel = MEM_W_PREV;
          rf_r0_addr_sel = RF_R0_ADDR_DR;
          rf_r0_rd       = 1'b1;
        end
      end

      S_HALT: begin
        halted = 1'b1;
      end

      default: state_next = S_INIT;
    endcase
  end

endmodule

// File: tb/tb_punc_control.sv
// Self-checking bench for punc_control: table of instructions plus reset/halt sequences.
module tb_punc_control;

  typedef struct packed {
    logic       pc_ld;
    logic       pc_clr;
    logic       pc_inc;
    logic [1:0] pc_sel;
    logic       ir_ld;
    logic       ir_clr;
    logic       mem_rd;
    logic       mem_wr;
    logic [1:0] mem_r_addr_sel;
    logic [1:0] mem_w_addr_sel;
    logic [1:0] rf_w_data_sel;
    logic       rf_w_addr_sel;
    logic       rf_w_wr;
    logic       rf_r0_addr_sel;
    logic       prev_ld;
    logic       nzp_ld;
    logic       nzp_clr;
    logic [1:0] alu_sel;
    logic       alu_first_val_sel;
    logic       halted;
  } out_t;

  typedef struct {
    string name;
    out_t  e;
  } sb_t;

  typedef struct {
    string       name;
    logic [15:0] ir;
    logic        nzp;
    out_t        ex;
    logic        two;
    out_t        ex2;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] ir;
  logic        nzp_true;
  logic        pc_ld, pc_clr, pc_inc, ir_ld, ir_clr, mem_rd, mem_wr;
  logic [1:0]  pc_sel, mem_r_addr_sel, mem_w_addr_sel, rf_w_data_sel, alu_sel;
  logic        rf_w_addr_sel, rf_w_wr, rf_r0_addr_sel, rf_r0_rd, rf_r1_rd;
  logic        prev_ld, nzp_ld, nzp_clr, alu_first_val_sel, halted;

  int checks   = 0;
  int failures = 0;
  sb_t sb_q[$];
  out_t act;

  always #5 clk = ~clk;

  punc_control dut (
    .clk(clk), .rst(rst), .ir(ir), .nzp_true(nzp_true),
    .pc_ld(pc_ld), .pc_clr(pc_clr), .pc_inc(pc_inc), .pc_sel(pc_sel),
    .ir_ld(ir_ld), .ir_clr(ir_clr), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_r_addr_sel(mem_r_addr_sel), .mem_w_addr_sel(mem_w_addr_sel),
    .rf_w_data_sel(rf_w_data_sel), .rf_w_addr_sel(rf_w_addr_sel),
    .rf_w_wr(rf_w_wr), .rf_r0_addr_sel(rf_r0_addr_sel),
    .rf_r0_rd(rf_r0_rd), .rf_r1_rd(rf_r1_rd), .prev_ld(prev_ld),
    .nzp_ld(nzp_ld), .nzp_clr(nzp_clr), .alu_sel(alu_sel),
    .alu_first_val_sel(alu_first_val_sel), .halted(halted)
  );

  always_comb begin
    act.pc_ld             = pc_ld;
    act.pc_clr            = pc_clr;
    act.pc_inc            = pc_inc;
    act.pc_sel            = pc_sel;
    act.ir_ld             = ir_ld;
    act.ir_clr            = ir_clr;
    act.mem_rd            = mem_rd;
    act.mem_wr            = mem_wr;
    act.mem_r_addr_sel    = mem_r_addr_sel;
    act.mem_w_addr_sel    = mem_w_addr_sel;
    act.rf_w_data_sel     = rf_w_data_sel;
    act.rf_w_addr_sel     = rf_w_addr_sel;
    act.rf_w_wr           = rf_w_wr;
    act.rf_r0_addr_sel    = rf_r0_addr_sel;
    act.prev_ld           = prev_ld;
    act.nzp_ld            = nzp_ld;
    act.nzp_clr           = nzp_clr;
    act.alu_sel           = alu_sel;
    act.alu_first_val_sel = alu_first_val_sel;
    act.halted            = halted;
  end

  // Outputs are compared mid-cycle, one expectation per cycle.
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      sb_t s;
      s = sb_q.pop_front();
      checks++;
      if (act !== s.e) begin
        failures++;
        $display("FAIL %s: got=%h expected=%h", s.name, act, s.e);
      end
      if (pc_ld + pc_inc + pc_clr > 1 || (mem_wr && rf_w_wr)) begin
        failures++;
        $display("FAIL exclusivity %s: pc_ld/inc/clr=%b%b%b mem_wr=%b rf_w_wr=%b expected at most one",
                 s.name, pc_ld, pc_inc, pc_clr, mem_wr, rf_w_wr);
      end
    end
  end

  function automatic out_t zero();
    out_t o;
    o = '0;
    return o;
  endfunction

  task automatic step(input logic r, input logic [15:0] i, input logic n,
                      input out_t e, input string name);
    sb_t s;
    @(posedge clk);
    #1;
    rst      = r;
    ir       = i;
    nzp_true = n;
    s.name = name;
    s.e    = e;
    sb_q.push_back(s);
  endtask

  out_t e_init, e_fetch, e_halt, e;
  vec_t v[15];

  initial begin
    rst = 1'b1; ir = 16'h0000; nzp_true = 1'b0;

    e_init = zero(); e_init.pc_clr = 1; e_init.ir_clr = 1; e_init.nzp_clr = 1;
    e_fetch = zero(); e_fetch.mem_rd = 1; e_fetch.ir_ld = 1; e_fetch.pc_inc = 1;
    e_halt = zero(); e_halt.halted = 1;

    e = zero(); e.alu_sel = 1; e.alu_first_val_sel = 1; e.rf_r0_addr_sel = 1;
    e.rf_w_addr_sel = 1; e.rf_w_wr = 1; e.nzp_ld = 1;
    v[0] = '{"add_imm", 16'h1261, 1'b0, e, 1'b0, zero()};
    e = zero(); e.alu_sel = 2; e.rf_r0_addr_sel = 1;
    e.rf_w_addr_sel = 1; e.rf_w_wr = 1; e.nzp_ld = 1;
    v[1] = '{"and_reg", 16'h5042, 1'b1, e, 1'b0, zero()};
    e = zero(); e.alu_sel = 3; e.rf_w_addr_sel = 1; e.rf_w_wr = 1; e.nzp_ld = 1;
    v[2] = '{"not", 16'h927F, 1'b0, e, 1'b0, zero()};
    e = zero(); e.pc_ld = 1; e.pc_sel = 0;
    v[3] = '{"br_taken", 16'h0E05, 1'b1, e, 1'b0, zero()};
    v[4] = '{"br_not_taken", 16'h0E05, 1'b0, zero(), 1'b0, zero()};
    e = zero(); e.pc_ld = 1; e.pc_sel = 2;
    v[5] = '{"jmp", 16'hC1C0, 1'b0, e, 1'b0, zero()};
    e = zero(); e.rf_w_wr = 1; e.rf_w_addr_sel = 0; e.rf_w_data_sel = 3;
    e.pc_ld = 1; e.pc_sel = 1;
    v[6] = '{"jsr", 16'h4805, 1'b0, e, 1'b0, zero()};
    e.pc_sel = 2;
    v[7] = '{"jsrr_r7", 16'h41C0, 1'b0, e, 1'b0, zero()};
    e = zero(); e.mem_rd = 1; e.mem_r_addr_sel = 1; e.rf_w_data_sel = 2;
    e.rf_w_addr_sel = 1; e.rf_w_wr = 1; e.nzp_ld = 1;
    v[8] = '{"ld", 16'h2405, 1'b0, e, 1'b0, zero()};
    e.mem_r_addr_sel = 3;
    v[9] = '{"ldr", 16'h6442, 1'b0, e, 1'b0, zero()};
    e = zero(); e.rf_w_data_sel = 1; e.rf_w_addr_sel = 1; e.rf_w_wr = 1; e.nzp_ld = 1;
    v[10] = '{"lea", 16'hE405, 1'b0, e, 1'b0, zero()};
    e = zero(); e.mem_wr = 1; e.mem_w_addr_sel = 0;
    v[11] = '{"st", 16'h3405, 1'b0, e, 1'b0, zero()};
    e.mem_w_addr_sel = 2;
    v[12] = '{"str", 16'h7442, 1'b0, e, 1'b0, zero()};
    e = zero(); e.mem_rd = 1; e.mem_r_addr_sel = 1; e.rf_w_data_sel = 2;
    e.rf_w_addr_sel = 1; e.rf_w_wr = 1;
    v[13] = '{"ldi", 16'hA403, 1'b0, e, 1'b1, zero()};
    v[13].ex2 = e; v[13].ex2.mem_r_addr_sel = 2; v[13].ex2.nzp_ld = 1;
    e = zero(); e.mem_rd = 1; e.mem_r_addr_sel = 1; e.prev_ld = 1;
    v[14] = '{"sti", 16'hB403, 1'b0, e, 1'b1, zero()};
    v[14].ex2 = zero(); v[14].ex2.mem_wr = 1; v[14].ex2.mem_w_addr_sel = 1;

    // Reset held, then released: one INIT cycle before FETCH.
    step(1'b1, 16'h0000, 1'b0, e_init, "reset_held");
    step(1'b0, 16'h0000, 1'b0, e_init, "init_after_release");

    foreach (v[k]) begin
      step(1'b0, v[k].ir, v[k].nzp, e_fetch, {v[k].name, "_fetch"});
      step(1'b0, v[k].ir, v[k].nzp, zero(), {v[k].name, "_decode"});
      step(1'b0, v[k].ir, v[k].nzp, v[k].ex, {v[k].name, "_exec"});
      if (v[k].two)
        step(1'b0, v[k].ir, v[k].nzp, v[k].ex2, {v[k].name, "_exec2"});
    end

    // Opcodes 1000 and 1101 are 3-cycle NOPs.
    step(1'b0, 16'h8000, 1'b1, e_fetch, "nop8_fetch");
    step(1'b0, 16'h8000, 1'b1, zero(), "nop8_decode");
    step(1'b0, 16'h8000, 1'b1, zero(), "nop8_exec");
    step(1'b0, 16'hD000, 1'b1, e_fetch, "nopd_fetch");
    step(1'b0, 16'hD000, 1'b1, zero(), "nopd_decode");
    step(1'b0, 16'hD000, 1'b1, zero(), "nopd_exec");

    // Reset in the middle of an LDI abandons it before EXEC2.
    step(1'b0, 16'hA403, 1'b0, e_fetch, "ldi_abort_fetch");
    step(1'b0, 16'hA403, 1'b0, zero(), "ldi_abort_decode");
    step(1'b1, 16'hA403, 1'b0, e_init, "ldi_abort_reset");
    step(1'b0, 16'hA403, 1'b0, e_init, "ldi_abort_init");

    // HALT: reached after DECODE, held, left only by asynchronous reset.
    step(1'b0, 16'hF025, 1'b0, e_fetch, "halt_fetch");
    step(1'b0, 16'hF025, 1'b0, zero(), "halt_decode");
    for (int c = 0; c < 10; c++)
      step(1'b0, 16'h1261, 1'b1, e_halt, "halt_hold");
    step(1'b1, 16'h1261, 1'b0, e_init, "halt_reset_async");
    step(1'b0, 16'h1261, 1'b0, e_init, "halt_reset_init");
    step(1'b0, 16'h1261, 1'b0, e_fetch, "after_halt_fetch");

    @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: pending=%0d expected=0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/punc_control.md
# punc_control

Control FSM for the PUnC LC-3 processor; sits directly upstream of the datapath. Consumes the instruction register and the branch-condition flag. Drives every load, clear, select and enable into the datapath to sequence fetch, decode and execute of the LC-3 subset.

## Interface
- No parameters. All encodings come from the shared defines.
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-high.
- `ir` in 16: current instruction from the datapath.
- `nzp_true` in 1: branch condition; `(ir[11]&n)|(ir[10]&z)|(ir[9]&p)`.
- `pc_ld`, `pc_clr`, `pc_inc` out 1: PC load, clear, increment.
- `pc_sel` out 2: 0 = PC+sext(ir[8:0]), 1 = PC+sext(ir[10:0]), 2 = R[ir[8:6]].
- `ir_ld`, `ir_clr` out 1: IR load, clear.
- `mem_rd`, `mem_wr` out 1: memory read strobe, write enable.
- `mem_r_addr_sel` out 2: 0 = PC, 1 = PC+off9, 2 = R0 port data, 3 = R[ir[8:6]]+off6.
- `mem_w_addr_sel` out 2: 0 = PC+off9, 1 = prev, 2 = R[ir[8:6]]+off6.
- `rf_w_data_sel` out 2: 0 = ALU, 1 = PC+off9, 2 = memory read data, 3 = PC.
- `rf_w_addr_sel` out 1: 0 = R7, 1 = ir[11:9].
- `rf_w_wr` out 1: register-file write enable.
- `rf_r0_addr_sel` out 1: 0 = ir[11:9], 1 = ir[2:0].
- `rf_r0_rd`, `rf_r1_rd` out 1: read strobes.
- `prev_ld` out 1: latch memory read data into prev.
- `nzp_ld`, `nzp_clr` out 1: condition-code load, clear.
- `alu_sel` out 2: 0 = pass A, 1 = ADD, 2 = AND, 3 = NOT(B).
- `alu_first_val_sel` out 1: 0 = R0 port data, 1 = sext(ir[4:0]).
- `halted` out 1: high while in HALT.

## Operation
- States: INIT, FETCH, DECODE, EXEC, EXEC2, HALT.
- INIT:
  - Assert `pc_clr`, `ir_clr`, `nzp_clr`.
  - Next state FETCH.
- FETCH: `mem_rd`, `mem_r_addr_sel`=0, `ir_ld`, `pc_inc`. Next state DECODE.
- DECODE: no datapath writes. Next state is HALT for opcode 1111, otherwise EXEC.
- EXEC, by opcode `ir[15:12]`:
  - ADD 0001 / AND 0101:
    - `alu_sel` 1/2; `alu_first_val_sel`=`ir[5]`; `rf_r0_addr_sel`=1.
    - `rf_w_data_sel`=0, `rf_w_addr_sel`=1, `rf_w_wr`, `nzp_ld`.
  - NOT 1001: `alu_sel`=3, then write as for ADD.
  - BR 0000: `pc_ld` with `pc_sel`=0 only if `nzp_true`.
  - JMP/RET 1100: `pc_ld`, `pc_sel`=2.
  - JSR/JSRR 0100:
    - `rf_w_wr`, `rf_w_addr_sel`=0, `rf_w_data_sel`=3 (writes the incremented PC).
    - `pc_ld` with `pc_sel` = 1 if `ir[11]`, else 2.
    - JSRR with base R7 uses the old R7.
  - LD 0010 / LDR 0110:
    - `mem_rd`; `mem_r_addr_sel` 1/3; `rf_w_data_sel`=2.
    - `rf_w_addr_sel`=1, `rf_w_wr`, `nzp_ld`.
  - LEA 1110: `rf_w_data_sel`=1, write DR, `nzp_ld`.
  - ST 0011 / STR 0111: `mem_wr`; `mem_w_addr_sel` 0/2; `rf_r0_addr_sel`=0; `rf_r0_rd`.
  - LDI 1010: `mem_rd`, `mem_r_addr_sel`=1, write DR from memory (pointer). No `nzp_ld`. Next state EXEC2.
  - STI 1011: `mem_rd`, `mem_r_addr_sel`=1, `prev_ld`. Next state EXEC2.
  - Opcodes 1000 and 1101 are NOPs.
- EXEC2:
  - LDI: `mem_r_addr_sel`=2, `rf_r0_addr_sel`=0, write DR from memory, `nzp_ld`.
  - STI: `mem_w_addr_sel`=1, `rf_r0_addr_sel`=0, `mem_wr`.
- After EXEC (or EXEC2), next state is FETCH.
- HALT: all outputs 0 except `halted`=1. Only reset leaves HALT.
- Outputs are combinational from state and `ir`. Any output not listed for a state is 0.

## Timing
- `rst` high forces state INIT asynchronously.
  - Outputs in INIT: clears=1, all else 0, `halted`=0.
  - Reset mid-instruction abandons it with no partial write after the reset edge.
- Datapath clears take effect on the first rising edge after `rst` deasserts.
- Latency:
  - 3 cycles per instruction (FETCH, DECODE, EXEC).
  - 4 cycles for LDI/STI.
  - HALT is reached 2 cycles after FETCH of 0xF000-class opcodes.
- At most one of `pc_inc`, `pc_ld`, `pc_clr` is high in any cycle.
- `mem_wr` and `rf_w_wr` are never both high.
- BR with `nzp_true`=0 is a 3-cycle NOP.

## Structure
- State encodings (3 bits) and all select encodings above belong in the shared defines package, alongside the datapath's select constants.
- No sub-module; the decode is a case statement inside the FSM.

## Test plan
- Reset, then release: one INIT cycle with `pc_clr`=`ir_clr`=`nzp_clr`=1, then FETCH with `ir_ld`=`pc_inc`=1.
- `ir`=0x1261 (ADD R1,R1,#1) in EXEC: `alu_sel`=1, `alu_first_val_sel`=1, `rf_w_wr`=1, `nzp_ld`=1; FETCH follows.
- `ir`=0x0E05 (BRnzp +5):
  - With `nzp_true`=1: `pc_ld`=1, `pc_sel`=0.
  - With `nzp_true`=0: `pc_ld`=0.
- `ir`=0xA403 (LDI R2):
  - EXEC: `mem_r_addr_sel`=1, `rf_w_wr`=1, `nzp_ld`=0.
  - EXEC2: `mem_r_addr_sel`=2, `rf_w_wr`=1, `nzp_ld`=1.
- `ir`=0xB403 (STI R2): EXEC `prev_ld`=1; EXEC2 `mem_wr`=1, `mem_w_addr_sel`=1.
- `ir`=0xF025: HALT after DECODE, `halted`=1 held for 10 cycles. Asserting `rst` mid-HALT returns to INIT immediately.
